data_memory_unit: RTL and testbench

Word-organised data memory for the single-cycle MIPS datapath, directly downstream of the ALU. The ALU result is the byte address.
- Performs MIPS byte, halfword and word loads and stores, with sign or zero extension on loads.
- Detects misaligned and out-of-range accesses, suppresses them, and latches the first fault into a sticky status register for the control unit.

---
 rtl/data_memory_unit_if.sv | 46 ++++
 rtl/data_memory_unit.sv | 173 +++++++++++++++++
 tb/tb_data_memory_unit.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_unit_if.sv
// Data memory bus between the ALU/control side and the data memory.
// Carries the request, store data, load result and fault status.
interface data_memory_unit_if;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;
    logic        load_unsigned;
    logic        fault_clear;
    logic [31:0] read_data;
    logic        access_fault;
    logic        fault_valid;
    logic [31:0] fault_addr;
    logic [1:0]  fault_cause;

    modport master (
        output address,
        output write_data,
        output mem_read,
        output mem_write,
        output size,
        output load_unsigned,
        output fault_clear,
        input  read_data,
        input  access_fault,
        input  fault_valid,
        input  fault_addr,
        input  fault_cause
    );

    modport slave (
        input  address,
        input  write_data,
        input  mem_read,
        input  mem_write,
        input  size,
        input  load_unsigned,
        input  fault_clear,
        output read_data,
        output access_fault,
        output fault_valid,
        output fault_addr,
        output fault_cause
    );
endinterface

// File: rtl/data_memory_unit.sv
// Big-endian word-organised data memory for the single-cycle datapath.
// Zero-latency loads, edge-committed stores, sticky first-fault capture.
module data_memory_unit #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_BITS   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    data_memory_unit_if.slave bus
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam logic [1:0] C_NONE  = 2'b00;
    localparam logic [1:0] C_ALIGN = 2'b01;
    localparam logic [1:0] C_RANGE = 2'b10;
    localparam logic [1:0] C_SIZE  = 2'b11;

    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic             r_fault_valid;
    logic [31:0]      r_fault_addr;
    logic [1:0]       r_fault_cause;

    logic             w_req;
    logic             w_misal;
    logic             w_oor;
    logic [1:0]       w_cause;
    logic             w_fault;
    logic [ADDR_BITS-1:0] w_idx;
    logic [31:0]      w_word;
    logic [1:0]       w_off;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load;
    logic [3:0]       w_lane;
    logic [31:0]      w_bmask;
    logic [31:0]      w_wdata;
    logic             w_commit;

    assign w_req = bus.mem_read | bus.mem_write;
    assign w_off = bus.address[1:0];
    assign w_idx = bus.address[ADDR_BITS+1:2];
    assign w_word = r_mem[w_idx];

    // Upper address bits only matter here; there is no aliasing.
    assign w_oor = ({1'b0, bus.address} >= LIMIT);

    // Natural alignment check for halfword and word accesses.
    always_comb begin
        w_misal = 1'b0;
        unique case (1'b1)
            (bus.size == SZ_HALF): w_misal = w_off[0];
            (bus.size == SZ_WORD): w_misal = |w_off;
            default:               w_misal = 1'b0;
        endcase
    end

    // Prioritised fault cause: illegal size, then range, then alignment.
    always_comb begin
        w_cause = C_NONE;
        if (!w_req) begin
            w_cause = C_NONE;
        end else if (bus.size == SZ_ILL) begin
            w_cause = C_SIZE;
        end else if (w_oor) begin
            w_cause = C_RANGE;
        end else if (w_misal) begin
            w_cause = C_ALIGN;
        end
    end

    assign w_fault  = (w_cause != C_NONE);
    assign w_commit = bus.mem_write & ~w_fault;

    // Big-endian lane extraction for sub-word loads.
    always_comb begin
        w_byte = 8'h00;
        w_half = 16'h0000;
        unique case (w_off)
            2'd0: w_byte = w_word[31:24];
            2'd1: w_byte = w_word[23:16];
            2'd2: w_byte = w_word[15:8];
            2'd3: w_byte = w_word[7:0];
            default: w_byte = 8'h00;
        endcase
        w_half = w_off[1] ? w_word[15:0] : w_word[31:16];
    end

    // Load result with sign or zero extension; zero when idle or faulting.
    always_comb begin
        w_load = 32'h0;
        unique case (bus.size)
            SZ_BYTE: w_load = bus.load_unsigned ?
                              {24'h0, w_byte} :
                              {{24{w_byte[7]}}, w_byte};
            SZ_HALF: w_load = bus.load_unsigned ?
                              {16'h0, w_half} :
                              {{16{w_half[15]}}, w_half};
            SZ_WORD: w_load = w_word;
            default: w_load = 32'h0;
        endcase
        if (!bus.mem_read || w_fault) begin
            w_load = 32'h0;
        end
    end

    // Store lane enables and right-justified data replicated onto lanes.
    always_comb begin
        w_lane  = 4'b0000;
        w_wdata = 32'h0;
        unique case (bus.size)
            SZ_BYTE: begin
                w_lane  = 4'b1000 >> w_off;
                w_wdata = {4{bus.write_data[7:0]}};
            end
            SZ_HALF: begin
                w_lane  = w_off[1] ? 4'b0011 : 4'b1100;
                w_wdata = {2{bus.write_data[15:0]}};
            end
            SZ_WORD: begin
                w_lane  = 4'b1111;
                w_wdata = bus.write_data;
            end
            default: begin
                w_lane  = 4'b0000;
                w_wdata = 32'h0;
            end
        endcase
        w_bmask = {{8{w_lane[3]}}, {8{w_lane[2]}},
                   {8{w_lane[1]}}, {8{w_lane[0]}}};
    end

    // Memory array: cleared by reset, byte-lane merge on a clean store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                r_mem[i] <= 32'h0;
            end
        end else if (w_commit) begin
            r_mem[w_idx] <= (w_word & ~w_bmask) | (w_wdata & w_bmask);
        end
    end

    // Sticky fault record: first fault wins, clear yields to a new fault.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault_valid <= 1'b0;
            r_fault_addr  <= 32'h0;
            r_fault_cause <= C_NONE;
        end else if (w_fault && (bus.fault_clear || !r_fault_valid)) begin
            r_fault_valid <= 1'b1;
            r_fault_addr  <= bus.address;
            r_fault_cause <= w_cause;
        end else if (bus.fault_clear) begin
            r_fault_valid <= 1'b0;
            r_fault_addr  <= 32'h0;
            r_fault_cause <= C_NONE;
        end
    end

    assign bus.read_data    = rst_n ? w_load : 32'h0;
    assign bus.access_fault = rst_n & w_fault;
    assign bus.fault_valid  = r_fault_valid;
    assign bus.fault_addr   = r_fault_addr;
    assign bus.fault_cause  = r_fault_cause;

endmodule

// File: tb/tb_data_memory_unit.sv
// Bench for data_memory_unit: directed plan steps, then random traffic
// checked against a byte-addressed big-endian reference model.
module tb_data_memory_unit;

    localparam int NBYTES = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    data_memory_unit_if bus ();

    data_memory_unit #(
        .DEPTH_WORDS(256),
        .ADDR_BITS  (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  mb [NBYTES];
    logic        m_fv;
    logic [31:0] m_fa;
    logic [1:0]  m_fc;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] m_cause(input bit req,
                                           input logic [31:0] a,
                                           input logic [1:0] sz);
        if (!req) return 2'd0;
        if (sz == 2'd3) return 2'd3;
        if (a >= 32'(NBYTES)) return 2'd2;
        if (sz == 2'd1 && a % 2 != 0) return 2'd1;
        if (sz == 2'd2 && a % 4 != 0) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a,
                                           input logic [1:0] sz,
                                           input bit uns);
        int b = int'(a);
        logic [31:0] v;
        case (sz)
            2'd0: begin
                v = {24'h0, mb[b]};
                if (!uns && mb[b][7]) v = v | 32'hFFFF_FF00;
            end
            2'd1: begin
                v = {16'h0, mb[b], mb[b+1]};
                if (!uns && mb[b][7]) v = v | 32'hFFFF_0000;
            end
            default: v = {mb[b], mb[b+1], mb[b+2], mb[b+3]};
        endcase
        return v;
    endfunction

    task automatic m_store(input logic [31:0] a, input logic [1:0] sz,
                           input logic [31:0] wd);
        int b = int'(a);
        case (sz)
            2'd0: mb[b] = wd[7:0];
            2'd1: begin
                mb[b]   = wd[15:8];
                mb[b+1] = wd[7:0];
            end
            default: begin
                mb[b]   = wd[31:24];
                mb[b+1] = wd[23:16];
                mb[b+2] = wd[15:8];
                mb[b+3] = wd[7:0];
            end
        endcase
    endtask

    task automatic m_reset();
        for (int i = 0; i < NBYTES; i++) mb[i] = 8'h00;
        m_fv = 1'b0;
        m_fa = 32'h0;
        m_fc = 2'd0;
    endtask

    task automatic idle();
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.fault_clear   = 1'b0;
        bus.size          = 2'd2;
        bus.load_unsigned = 1'b0;
        bus.address       = 32'h0;
        bus.write_data    = 32'h0;
    endtask

    task automatic access(input bit rd, input bit wr,
                          input logic [31:0] a, input logic [1:0] sz,
                          input bit uns, input logic [31:0] wd,
                          input bit clr, output logic [31:0] rd_obs);
        logic [1:0]  c;
        logic [31:0] er;
        @(negedge clk);
        bus.mem_read      = rd;
        bus.mem_write     = wr;
        bus.address       = a;
        bus.size          = sz;
        bus.load_unsigned = uns;
        bus.write_data    = wd;
        bus.fault_clear   = clr;
        #1;
        c  = m_cause(rd | wr, a, sz);
        er = (rd && c == 2'd0) ? m_load(a, sz, uns) : 32'h0;
        check("read_data", bus.read_data, er);
        check("access_fault", 32'(bus.access_fault), 32'(c != 2'd0));
        rd_obs = bus.read_data;
        @(posedge clk);
        if (wr && c == 2'd0) m_store(a, sz, wd);
        if (c != 2'd0 && (clr || !m_fv)) begin
            m_fv = 1'b1;
            m_fa = a;
            m_fc = c;
        end else if (clr) begin
            m_fv = 1'b0;
            m_fa = 32'h0;
            m_fc = 2'd0;
        end
        #1;
        check("fault_valid", 32'(bus.fault_valid), 32'(m_fv));
        check("fault_addr", bus.fault_addr, m_fa);
        check("fault_cause", 32'(bus.fault_cause), 32'(m_fc));
        idle();
    endtask

    logic [31:0] r;
    logic [31:0] ra;
    logic [1:0]  rs;

    initial begin
        idle();
        m_reset();
        bus.mem_read = 1'b1;
        bus.size     = 2'd3;
        repeat (2) @(posedge clk);
        #1;
        check("rst read_data", bus.read_data, 32'h0);
        check("rst access_fault", 32'(bus.access_fault), 32'h0);
        check("rst fault_valid", 32'(bus.fault_valid), 32'h0);
        check("rst fault_addr", bus.fault_addr, 32'h0);
        check("rst fault_cause", 32'(bus.fault_cause), 32'h0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;

        access(0, 1, 32'h10, 2'd2, 0, 32'h8000_00F1, 0, r);
        access(1, 0, 32'h10, 2'd2, 0, 32'h0, 0, r);
        check("lw 0x10", r, 32'h8000_00F1);

        access(0, 1, 32'h13, 2'd0, 0, 32'h0000_0055, 0, r);
        access(1, 0, 32'h10, 2'd2, 0, 32'h0, 0, r);
        check("lw after sb", r, 32'h8000_0055);
        access(1, 0, 32'h10, 2'd0, 0, 32'h0, 0, r);
        check("lb 0x10", r, 32'hFFFF_FF80);
        access(1, 0, 32'h10, 2'd0, 1, 32'h0, 0, r);
        check("lbu 0x10", r, 32'h0000_0080);
        access(1, 0, 32'h12, 2'd1, 0, 32'h0, 0, r);
        check("lh 0x12", r, 32'h0000_0055);

        access(0, 1, 32'h12, 2'd2, 0, 32'hFFFF_FFFF, 0, r);
        check("misal fault_cause", 32'(bus.fault_cause), 32'h1);
        check("misal fault_addr", bus.fault_addr, 32'h12);
        access(1, 0, 32'h400, 2'd2, 0, 32'h0, 0, r);
        check("range ignored addr", bus.fault_addr, 32'h12);
        access(1, 0, 32'h10, 2'd2, 0, 32'h0, 0, r);
        check("mem unchanged", r, 32'h8000_0055);

        access(0, 0, 32'h0, 2'd2, 0, 32'h0, 1, r);
        check("clear valid", 32'(bus.fault_valid), 32'h0);
        access(1, 0, 32'h4, 2'd3, 0, 32'h0, 1, r);
        check("clr+fault cause", 32'(bus.fault_cause), 32'h3);
        check("clr+fault addr", bus.fault_addr, 32'h4);
        access(0, 0, 32'h0, 2'd2, 0, 32'h0, 1, r);

        access(0, 1, 32'h20, 2'd2, 0, 32'h1111_1111, 0, r);
        access(1, 1, 32'h20, 2'd2, 0, 32'h2222_2222, 0, r);
        check("rbw old", r, 32'h1111_1111);
        access(1, 0, 32'h20, 2'd2, 0, 32'h0, 0, r);
        check("rbw new", r, 32'h2222_2222);

        for (int i = 0; i < 400; i++) begin
            rs = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 15) == 0) rs = 2'd3;
            ra = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) begin
                ra = ra & ((rs == 2'd2) ? 32'hFFFF_FFFC :
                           (rs == 2'd1) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
            end
            if ($urandom_range(0, 15) == 0) ra = $urandom;
            if ($urandom_range(0, 15) == 0) ra = 32'(NBYTES - 4 + $urandom_range(0, 7));
            access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ra, rs, 1'($urandom_range(0, 1)), $urandom,
                   ($urandom_range(0, 7) == 0), r);
        end

        access(0, 1, 32'h9, 2'd2, 0, 32'h0, 0, r);
        check("pre-reset valid", 32'(bus.fault_valid), 32'h1);
        @(negedge clk);
        bus.mem_read   = 1'b1;
        bus.mem_write  = 1'b1;
        bus.address    = 32'h8;
        bus.size       = 2'd2;
        bus.write_data = 32'hDEAD_BEEF;
        #2;
        rst_n = 1'b0;
        #1;
        check("in-rst fault_valid", 32'(bus.fault_valid), 32'h0);
        check("in-rst read_data", bus.read_data, 32'h0);
        @(posedge clk);
        #1;
        check("in-rst read_data edge", bus.read_data, 32'h0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        m_reset();
        access(1, 0, 32'h8, 2'd2, 0, 32'h0, 0, r);
        check("lw 0x8 after rst", r, 32'h0);
        access(1, 0, 32'h20, 2'd2, 0, 32'h0, 0, r);
        check("lw 0x20 after rst", r, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
